// File: rtl/polyvec_pair_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// polyvec_pair_loader: packs a normalised coefficient stream into (even, odd)
// pairs and writes them into one operand bank of the polyvec accumulator.
// Revision: 1.0
// ---------------------------------------------------------------------------
module polyvec_pair_loader #(
    parameter int DEPTH   = 8,
    parameter int KYBER_K = 3,
    parameter int KYBER_Q = 3329,
    parameter int REDUCE  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             readin_ok,
    output logic             readin,
    output logic [15:0]      dout_1,
    output logic [15:0]      dout_2,
    output logic [DEPTH-1:0] index,
    output logic [3:0]       k,
    output logic             full_in,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_OK = 3'd1,
        S_LOAD_LO = 3'd2,
        S_LOAD_HI = 3'd3,
        S_WRITE   = 3'd4,
        S_FULL    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [DEPTH-1:0] LAST_IDX = {{(DEPTH-1){1'b1}}, 1'b0};
    localparam logic [DEPTH-1:0] IDX_STEP = DEPTH'(2);
    localparam logic [3:0]       LAST_K   = 4'(KYBER_K - 1);

    state_t           state_q, state_d;
    logic [DEPTH-1:0] index_q, index_d;
    logic [3:0]       k_q, k_d;
    logic [15:0]      lo_q, lo_d;
    logic [15:0]      dout_1_q, dout_1_d;
    logic [15:0]      dout_2_q, dout_2_d;
    logic [15:0]      norm_data;

    generate
        if (REDUCE != 0) begin : g_reduce
            localparam logic signed [16:0] Q17 = 17'(KYBER_Q);
            logic signed [16:0] norm_ext;
            logic signed [16:0] norm_sum;

            // One conditional add/subtract of Q folds [-Q, 2Q) into [0, Q).
            always_comb begin
                norm_ext = {in_data[15], in_data};
                if (norm_ext[16]) begin
                    norm_sum = norm_ext + Q17;
                end else if (norm_ext >= Q17) begin
                    norm_sum = norm_ext - Q17;
                end else begin
                    norm_sum = norm_ext;
                end
            end

            assign norm_data = norm_sum[15:0];
        end else begin : g_pass
            assign norm_data = in_data;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            index_q  <= '0;
            k_q      <= '0;
            lo_q     <= '0;
            dout_1_q <= '0;
            dout_2_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            k_q      <= k_d;
            lo_q     <= lo_d;
            dout_1_q <= dout_1_d;
            dout_2_q <= dout_2_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        k_d      = k_q;
        lo_d     = lo_q;
        dout_1_d = dout_1_q;
        dout_2_d = dout_2_q;
        in_ready = 1'b0;
        readin   = 1'b0;
        full_in  = 1'b0;

        if (set) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_WAIT_OK;
                        index_d = '0;
                        k_d     = '0;
                    end
                end
                S_WAIT_OK: begin
                    if (readin_ok) begin
                        state_d = S_LOAD_LO;
                    end
                end
                S_LOAD_LO: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        lo_d    = norm_data;
                        state_d = S_LOAD_HI;
                    end
                end
                S_LOAD_HI: begin
                    in_ready = 1'b1;
                    // The output pair is captured whole here so it only moves on entry to WRITE.
                    if (in_valid) begin
                        dout_1_d = lo_q;
                        dout_2_d = norm_data;
                        state_d  = S_WRITE;
                    end
                end
                S_WRITE: begin
                    readin = 1'b1;
                    if (index_q == LAST_IDX && k_q == LAST_K) begin
                        state_d = S_FULL;
                    end else begin
                        index_d = index_q + IDX_STEP;
                        if (index_q == LAST_IDX) begin
                            k_d = k_q + 4'd1;
                        end
                        state_d = readin_ok ? S_LOAD_LO : S_WAIT_OK;
                    end
                end
                S_FULL: begin
                    full_in = 1'b1;
                    state_d = S_DONE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign dout_1 = dout_1_q;
    assign dout_2 = dout_2_q;
    assign index  = index_q;
    assign k      = k_q;
    assign busy   = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done   = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_polyvec_pair_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_polyvec_pair_loader: directed table-driven bench for polyvec_pair_loader.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_polyvec_pair_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        set = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        readin_ok = 1'b0;
    logic        readin;
    logic [15:0] dout_1;
    logic [15:0] dout_2;
    logic [7:0]  index;
    logic [3:0]  k;
    logic        full_in;
    logic        busy;
    logic        done;

    polyvec_pair_loader dut (
        .clk       (clk),
        .reset     (reset),
        .set       (set),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .readin_ok (readin_ok),
        .readin    (readin),
        .dout_1    (dout_1),
        .dout_2    (dout_2),
        .index     (index),
        .k         (k),
        .full_in   (full_in),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;

    vec_t        tbl [0:5];
    logic [15:0] coef  [0:767];
    logic [15:0] exp_d [0:767];

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;

    int          nwr   = 0;
    int          nfull = 0;
    logic [7:0]  wr_idx [0:1023];
    logic [3:0]  wr_k   [0:1023];
    logic [15:0] wr_d1  [0:1023];
    logic [15:0] wr_d2  [0:1023];
    int          wr_cyc [0:1023];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (readin && nwr < 1024) begin
            wr_idx[nwr] <= index;
            wr_k[nwr]   <= k;
            wr_d1[nwr]  <= dout_1;
            wr_d2[nwr]  <= dout_2;
            wr_cyc[nwr] <= cyc;
            nwr         <= nwr + 1;
        end
        if (full_in) nfull <= nfull + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Feeds coef[first..last-1]; optionally drops set for 5 cycles once coef count hits drop_at.
    task automatic stream(input int first, input int last, input bit rnd, input int drop_at);
        int i = first;
        int guard = 0;
        bit dropped = 1'b0;
        while (i < last && guard < 8 * (last - first) + 100) begin
            if (i == drop_at && !dropped) begin
                dropped = 1'b1;
                set = 1'b0;
                for (int c = 0; c < 5; c++) begin
                    in_valid = 1'b1;
                    in_data  = coef[i];
                    @(negedge clk);
                    check("set_low_in_ready", in_ready, 0);
                    check("set_low_readin", readin, 0);
                    tick();
                end
                set = 1'b1;
            end
            in_data  = coef[i];
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (in_valid && in_ready) i++;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        check("stream_accepted", i, last);
    endtask

    task automatic wait_done(input string name);
        int c = 0;
        while (!done && c < 50) begin
            tick();
            c++;
        end
        check(name, done, 1);
    endtask

    // Expected write j: index = 2*(j mod 128), k = j/128, data from exp_d.
    task automatic check_writes(input int base, input int n);
        for (int j = 0; j < n; j++) begin
            check($sformatf("write_%0d", j),
                  {wr_idx[base+j], wr_k[base+j], wr_d1[base+j], wr_d2[base+j]},
                  {8'(2 * (j % 128)), 4'(j / 128), exp_d[2*j], exp_d[2*j+1]});
        end
    endtask

    initial begin
        int base;
        int fbase;
        int bad_gap;

        tbl[0] = '{16'hFFFF, 16'd3329, 16'd3328, 16'd0};
        tbl[1] = '{16'd3328, 16'd6657, 16'd3328, 16'd3328};
        tbl[2] = '{16'd0,    16'hF2FF, 16'd0,    16'd0};
        tbl[3] = '{16'd100,  16'hFF9C, 16'd100,  16'd3229};
        tbl[4] = '{16'd3330, 16'hFFFE, 16'd1,    16'd3327};
        tbl[5] = '{16'd6000, 16'd1,    16'd2671, 16'd1};

        for (int i = 0; i < 768; i++) begin
            coef[i]  = 16'(i);
            exp_d[i] = 16'(i);
        end

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_readin", readin, 0);
        check("rst_full_in", full_in, 0);
        check("rst_busy_done", {busy, done}, 0);
        check("rst_index_k", {index, k}, 0);
        check("rst_dout", {dout_1, dout_2}, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        // Load 1: readin_ok held low, then a gap-free stream of 0..767
        base  = nwr;
        fbase = nfull;
        pulse_start();
        check("start_busy", busy, 1);
        in_valid = 1'b1;
        in_data  = coef[0];
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("wait_ok_in_ready", in_ready, 0);
            tick();
        end
        check("wait_ok_no_write", nwr - base, 0);
        readin_ok = 1'b1;
        @(negedge clk);
        check("ok_raised_same_cycle", in_ready, 0);
        tick();
        @(negedge clk);
        check("ok_raised_next_cycle", in_ready, 1);
        tick();
        stream(1, 768, 1'b0, -1);
        wait_done("load1_done");
        check("load1_busy", busy, 0);
        check("load1_writes", nwr - base, 384);
        check("load1_full_pulses", nfull - fbase, 1);
        check("load1_first", {wr_idx[base], wr_k[base], wr_d1[base], wr_d2[base]},
              {8'd0, 4'd0, 16'd0, 16'd1});
        check("load1_w128", {wr_idx[base+128], wr_k[base+128], wr_d1[base+128], wr_d2[base+128]},
              {8'd0, 4'd1, 16'd256, 16'd257});
        check("load1_last", {wr_idx[base+383], wr_k[base+383], wr_d1[base+383], wr_d2[base+383]},
              {8'd254, 4'd2, 16'd766, 16'd767});
        bad_gap = 0;
        for (int j = 1; j < 384; j++) begin
            if (wr_cyc[base+j] - wr_cyc[base+j-1] != 3) bad_gap++;
        end
        check("load1_spacing", bad_gap, 0);
        check_writes(base, 384);

        // Load 2: start from DONE, normaliser table, ignored start, random valid, set gap
        for (int t = 0; t < 6; t++) begin
            coef[2*t]    = tbl[t].a;
            coef[2*t+1]  = tbl[t].b;
            exp_d[2*t]   = tbl[t].e1;
            exp_d[2*t+1] = tbl[t].e2;
        end
        base  = nwr;
        fbase = nfull;
        pulse_start();
        check("done_start_clears_done", done, 0);
        stream(0, 12, 1'b0, -1);
        repeat (3) tick();
        pulse_start();
        repeat (2) tick();
        check("ignored_start_busy", {busy, done}, 2'b10);
        check("ignored_start_writes", nwr - base, 6);
        stream(12, 768, 1'b1, 101);
        wait_done("load2_done");
        check("load2_writes", nwr - base, 384);
        check("load2_full_pulses", nfull - fbase, 1);
        for (int t = 0; t < 6; t++) begin
            check($sformatf("norm_vec_%0d", t), {wr_d1[base+t], wr_d2[base+t]},
                  {tbl[t].e1, tbl[t].e2});
        end
        check("after_ignored_start", {wr_idx[base+6], wr_k[base+6]}, {8'd12, 4'd0});
        check_writes(base, 384);

        // Load 3: asynchronous reset after 100 pairs, then restart from slot 0
        for (int i = 0; i < 12; i++) begin
            coef[i]  = 16'(i);
            exp_d[i] = 16'(i);
        end
        base = nwr;
        pulse_start();
        stream(0, 200, 1'b0, -1);
        repeat (2) tick();
        check("pre_reset_writes", nwr - base, 100);
        check("pre_reset_index", index, 200);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_index_k", {index, k}, 0);
        check("async_rst_dout", {dout_1, dout_2}, 0);
        check("async_rst_flags", {in_ready, readin, full_in, busy, done}, 0);
        tick();
        reset = 1'b0;
        base = nwr;
        pulse_start();
        stream(0, 4, 1'b0, -1);
        repeat (2) tick();
        check("restart_writes", nwr - base, 2);
        check("restart_w0", {wr_idx[base], wr_k[base], wr_d1[base], wr_d2[base]},
              {8'd0, 4'd0, 16'd0, 16'd1});
        check("restart_w1", {wr_idx[base+1], wr_k[base+1], wr_d1[base+1], wr_d2[base+1]},
              {8'd2, 4'd0, 16'd2, 16'd3});

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
`default_nettype wire
